fifo_serial_tx: RTL

- Downstream consumer of the team's synchronous FIFO.
- Pops one word at a time through the FIFO read port (rd_en / rdata / empty) and shifts it out MSB-first on a single-bit serial line.
- Provides a frame-valid signal, a per-bit strobe, and a configurable idle gap between words.
- Sits between the FIFO and the off-block serial link.

---
 rtl/fifo_serial_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fifo_serial_tx.sv
// Serial transmitter that pops words from a synchronous FIFO and shifts each one out MSB-first.
// Optional macro FIFO_SERIAL_TX_PARITY_EN appends an even-parity bit after the LSB of every frame.
module fifo_serial_tx #(
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 4,
  parameter int GAP_BITS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_en_o,
  output logic                  ser_data_o,
  output logic                  ser_frame_o,
  output logic                  ser_bit_strobe_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  word_count_o
);

`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NBITS = DATA_WIDTH + 1;
`else
  localparam int NBITS = DATA_WIDTH;
`endif
  localparam int GAP_CYCLES = GAP_BITS * CLK_DIV;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, GAP} state_t;

  state_t               state_q, state_d;
  logic [NBITS-1:0]     shift_q, shift_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 rd_en_q, rd_en_d;
  logic                 data_q, data_d;
  logic                 frame_q, frame_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 start;

  // FIFO emptiness only matters at the IDLE / end-of-gap decision point.
  assign start = enable_i & ~fifo_empty_i;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rd_en_d  = 1'b0;
    data_d   = data_q;
    frame_d  = frame_q;
    strobe_d = 1'b0;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
        shift_d = {fifo_rdata_i, ^fifo_rdata_i};
`else
        shift_d = fifo_rdata_i;
`endif
        state_d  = SHIFT;
        frame_d  = 1'b1;
        data_d   = shift_d[NBITS-1];
        strobe_d = 1'b1;
        div_d    = '0;
        bit_d    = '0;
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d    = bit_q + BIT_W'(1);
            shift_d  = {shift_q[NBITS-2:0], 1'b0};
            data_d   = shift_d[NBITS-1];
            strobe_d = 1'b1;
          end else begin
            frame_d = 1'b0;
            data_d  = 1'b0;
            count_d = count_q + CNT_WIDTH'(1);
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end else if (start) begin
              state_d = FETCH;
              rd_en_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (start) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // A reset mid-frame simply drops the word; it was already popped from the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      rd_en_q  <= 1'b0;
      data_q   <= 1'b0;
      frame_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      rd_en_q  <= rd_en_d;
      data_q   <= data_d;
      frame_q  <= frame_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  assign fifo_rd_en_o     = rd_en_q;
  assign ser_data_o       = data_q;
  assign ser_frame_o      = frame_q;
  assign ser_bit_strobe_o = strobe_q;
  assign busy_o           = busy_q;
  assign word_count_o     = count_q;

endmodule
